// File: rtl/quad_and_bist_pkg.sv
// Shared types and helpers for the quad AND-gate BIST sequencer.
// Pure declarations; no timing. No flow control.
package quad_and_bist_pkg;

    localparam int NUM_GATES   = 4;
    localparam int NUM_VECTORS = 4;

    typedef enum logic [3:0] {
        IDLE,
        PWR_UP,
        APPLY,
        SETTLE,
        CHECK,
        OFF_APPLY,
        OFF_SETTLE,
        OFF_CHECK,
        DONE
    } bist_state_t;

    // Gate g sees input combination (k+g) mod 4 as {a,b}.
    function automatic logic [1:0] vec_ab(input logic [1:0] k, input int g);
        return k + 2'(g);
    endfunction

    function automatic logic exp_y(input logic [1:0] k, input int g);
        return vec_ab(k, g) == 2'd3;
    endfunction

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/quad_and_bist_ctrl_if.sv
// Pin bundle between the BIST sequencer (master) and the quad AND-gate macro (slave).
// Wires only; no latency. No flow control.
interface quad_and_bist_ctrl_if;
    import quad_and_bist_pkg::*;

    logic [NUM_GATES-1:0] a_o;
    logic [NUM_GATES-1:0] b_o;
    logic                 vcc_o;
    logic                 vss_o;
    logic [NUM_GATES-1:0] y_i;

    modport master (output a_o, output b_o, output vcc_o, output vss_o, input y_i);
    modport slave  (input a_o, input b_o, input vcc_o, input vss_o, output y_i);
endinterface

// File: rtl/quad_and_bist_timer.sv
// Loadable down-counter with zero flag, shared by power-up and settle waits.
// Zero flag is combinational from the count; load takes effect next cycle. No flow control.
module quad_and_bist_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/quad_and_bist_ctrl.sv
// BIST sequencer for the quad AND-gate macro; optional power-off check under QUAD_AND_BIST_PWR_OFF_CHECK_EN.
// done one cycle after edge PWR_UP_CYCLES + 4*(SETTLE_CYCLES+2) (+SETTLE_CYCLES+2 with the off check).
// No backpressure: start is only sampled in IDLE and ignored while busy.
module quad_and_bist_ctrl
    import quad_and_bist_pkg::*;
#(
    parameter int PWR_UP_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    quad_and_bist_ctrl_if.master gate,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_GATES-1:0] fail_mask
);

    localparam int TW = $clog2(max_int(PWR_UP_CYCLES, SETTLE_CYCLES) + 1);

    bist_state_t          state;
    logic [1:0]           k;
    logic [1:0]           kn;
    logic [NUM_GATES-1:0] pat_a;
    logic [NUM_GATES-1:0] pat_b;
    logic [NUM_GATES-1:0] mism;
    logic [NUM_GATES-1:0] fm_next;
    logic                 tmr_load;
    logic [TW-1:0]        tmr_val;
    logic                 tmr_zero;

    quad_and_bist_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next vector pattern: k+1 when leaving CHECK, vector 0 when leaving PWR_UP.
    always_comb begin
        kn = (state == CHECK) ? (k + 2'd1) : 2'd0;
        for (int g = 0; g < NUM_GATES; g++) begin
            {pat_a[g], pat_b[g]} = vec_ab(kn, g);
            mism[g]              = gate.y_i[g] ^ exp_y(k, g);
        end
        fm_next = fail_mask | mism;
`ifdef QUAD_AND_BIST_PWR_OFF_CHECK_EN
        if (state == OFF_CHECK) begin
            fm_next = fail_mask | gate.y_i;
        end
`endif
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = TW'(SETTLE_CYCLES - 1);
        case (state)
            IDLE: begin
                tmr_load = start;
                tmr_val  = TW'(PWR_UP_CYCLES - 1);
            end
            APPLY:     tmr_load = 1'b1;
`ifdef QUAD_AND_BIST_PWR_OFF_CHECK_EN
            OFF_APPLY: tmr_load = 1'b1;
`endif
            default:   tmr_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= '0;
            gate.a_o   <= '0;
            gate.b_o   <= '0;
            gate.vcc_o <= 1'b0;
            gate.vss_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        fail_mask  <= '0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        k          <= 2'd0;
                        gate.vcc_o <= 1'b1;
                        gate.vss_o <= 1'b1;
                        gate.a_o   <= '0;
                        gate.b_o   <= '0;
                        state      <= PWR_UP;
                    end
                end
                PWR_UP: begin
                    if (tmr_zero) begin
                        gate.a_o <= pat_a;
                        gate.b_o <= pat_b;
                        state    <= APPLY;
                    end
                end
                APPLY: state <= SETTLE;
                SETTLE: begin
                    if (tmr_zero) state <= CHECK;
                end
                CHECK: begin
                    fail_mask <= fm_next;
                    if (k == 2'd3) begin
`ifdef QUAD_AND_BIST_PWR_OFF_CHECK_EN
                        // Unpowered gate must not pass A&B through.
                        gate.a_o   <= '1;
                        gate.b_o   <= '1;
                        gate.vcc_o <= 1'b0;
                        state      <= OFF_APPLY;
`else
                        pass       <= ~|fm_next;
                        done       <= 1'b1;
                        gate.a_o   <= '0;
                        gate.b_o   <= '0;
                        gate.vcc_o <= 1'b0;
                        gate.vss_o <= 1'b0;
                        state      <= DONE;
`endif
                    end else begin
                        k        <= kn;
                        gate.a_o <= pat_a;
                        gate.b_o <= pat_b;
                        state    <= APPLY;
                    end
                end
`ifdef QUAD_AND_BIST_PWR_OFF_CHECK_EN
                OFF_APPLY: state <= OFF_SETTLE;
                OFF_SETTLE: begin
                    if (tmr_zero) state <= OFF_CHECK;
                end
                OFF_CHECK: begin
                    fail_mask  <= fm_next;
                    pass       <= ~|fm_next;
                    done       <= 1'b1;
                    gate.a_o   <= '0;
                    gate.b_o   <= '0;
                    gate.vcc_o <= 1'b0;
                    gate.vss_o <= 1'b0;
                    state      <= DONE;
                end
`endif
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_and_bist_ctrl.sv
// Directed bench for quad_and_bist_ctrl with a behavioural gate model and injectable faults.
module tb_quad_and_bist_ctrl;

`ifdef QUAD_AND_BIST_PWR_OFF_CHECK_EN
    localparam int L = 24;
`else
    localparam int L = 20;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [3:0] fail_mask;
    logic [3:0] stuck0 = 4'b0000;
    logic [3:0] stuck1 = 4'b0000;
    logic       ign_vcc = 1'b0;
    int         checks = 0;
    int         failures = 0;

    quad_and_bist_ctrl_if gif ();

    quad_and_bist_ctrl #(.PWR_UP_CYCLES(4), .SETTLE_CYCLES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .gate      (gif),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [3:0] raw;
        raw = (ign_vcc || (gif.vcc_o && gif.vss_o)) ? (gif.a_o & gif.b_o) : 4'b0000;
        gif.y_i = (raw & ~stuck0) | stuck1;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs edges first_e..L+8 after an accepted start, optionally re-pulsing start.
    task automatic wait_done(input int first_e, input int repulse, output int fd, output int nd,
                             output logic [3:0] fm_d, output logic pass_d);
        fd = -1; nd = 0; fm_d = 4'hx; pass_d = 1'bx;
        for (int e = first_e; e <= L + 8; e++) begin
            if (e == repulse) start = 1'b1;
            @(posedge clk); #1;
            if (e == repulse) start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                if (fd < 0) begin
                    fd = e; fm_d = fail_mask; pass_d = pass;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #2;
        checks++; if ({busy, done, pass, fail_mask} !== 7'b0) begin failures++;
            $display("FAIL rst_ctrl got=%b exp=0", {busy, done, pass, fail_mask}); end
        checks++; if ({gif.vcc_o, gif.vss_o, gif.a_o, gif.b_o} !== 10'b0) begin failures++;
            $display("FAIL rst_pins got=%b exp=0", {gif.vcc_o, gif.vss_o, gif.a_o, gif.b_o}); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({busy, done, gif.vcc_o} !== 3'b0) begin failures++;
            $display("FAIL rst_idle got=%b exp=0", {busy, done, gif.vcc_o}); end
    endtask

    task automatic test_basic();
        int nd = 0;
        pulse_start();
        checks++; if ({busy, gif.vcc_o, gif.vss_o, gif.a_o, gif.b_o} !== 11'b111_0000_0000) begin failures++;
            $display("FAIL pwr_up got=%b exp=11100000000", {busy, gif.vcc_o, gif.vss_o, gif.a_o, gif.b_o}); end
        for (int e = 1; e <= L + 2; e++) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
            if (e == 4) begin
                checks++; if ({gif.a_o, gif.b_o} !== 8'b1100_1010) begin failures++;
                    $display("FAIL vec_k0 got=%b exp=11001010", {gif.a_o, gif.b_o}); end
            end
            if (e == 8) begin
                checks++; if ({gif.a_o, gif.b_o} !== 8'b0110_0101) begin failures++;
                    $display("FAIL vec_k1 got=%b exp=01100101", {gif.a_o, gif.b_o}); end
            end
            if (e == L) begin
                checks++; if ({done, busy, pass, fail_mask, gif.vcc_o, gif.vss_o} !== 9'b111_0000_00) begin failures++;
                    $display("FAIL done_basic got=%b exp=111000000", {done, busy, pass, fail_mask, gif.vcc_o, gif.vss_o}); end
            end
            if (e == L + 1) begin
                checks++; if ({done, busy, pass} !== 3'b001) begin failures++;
                    $display("FAIL after_done got=%b exp=001", {done, busy, pass}); end
            end
        end
        checks++; if (nd != 1) begin failures++;
            $display("FAIL basic_done_count got=%0d exp=1", nd); end
    endtask

    task automatic test_stuck0_gate2();
        int fd, nd; logic [3:0] fm; logic p;
        stuck0 = 4'b0100;
        pulse_start();
        wait_done(1, -1, fd, nd, fm, p);
        stuck0 = 4'b0000;
        checks++; if (fd != L) begin failures++; $display("FAIL s0_edge got=%0d exp=%0d", fd, L); end
        checks++; if ({fm, p} !== 5'b0100_0) begin failures++;
            $display("FAIL s0_result got=%b exp=01000", {fm, p}); end
        checks++; if ({fail_mask, pass} !== 5'b0100_0) begin failures++;
            $display("FAIL s0_held got=%b exp=01000", {fail_mask, pass}); end
    endtask

    task automatic test_stuck1_gate0();
        int fd, nd; logic [3:0] fm; logic p;
        stuck1 = 4'b0001;
        pulse_start();
        wait_done(1, -1, fd, nd, fm, p);
        stuck1 = 4'b0000;
        checks++; if ({fm, p} !== 5'b0001_0) begin failures++;
            $display("FAIL s1_result got=%b exp=00010", {fm, p}); end
        pulse_start();
        checks++; if ({fail_mask, pass} !== 5'b0) begin failures++;
            $display("FAIL s1_clear got=%b exp=00000", {fail_mask, pass}); end
        wait_done(1, -1, fd, nd, fm, p);
        checks++; if ({fm, p} !== 5'b0000_1) begin failures++;
            $display("FAIL s1_rerun got=%b exp=00001", {fm, p}); end
    endtask

    task automatic test_start_while_busy();
        int fd, nd; logic [3:0] fm; logic p;
        pulse_start();
        wait_done(1, 8, fd, nd, fm, p);
        checks++; if (fd != L) begin failures++; $display("FAIL busy_start_edge got=%0d exp=%0d", fd, L); end
        checks++; if (nd != 1) begin failures++; $display("FAIL busy_start_count got=%0d exp=1", nd); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int fd, nd; logic [3:0] fm; logic p;
        pulse_start();
        for (int e = 1; e <= 13; e++) begin @(posedge clk); #1; end
        checks++; if ({gif.vcc_o, gif.a_o, gif.b_o} !== 9'b1_0011_1010) begin failures++;
            $display("FAIL settle_k2 got=%b exp=100111010", {gif.vcc_o, gif.a_o, gif.b_o}); end
        rst_n = 1'b0; #1;
        checks++; if ({gif.vcc_o, gif.vss_o, gif.a_o, gif.b_o, busy, done, fail_mask} !== 16'b0) begin failures++;
            $display("FAIL mid_reset got=%b exp=0", {gif.vcc_o, gif.vss_o, gif.a_o, gif.b_o, busy, done, fail_mask}); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        wait_done(1, -1, fd, nd, fm, p);
        checks++; if (fd != L || {fm, p} !== 5'b0000_1) begin failures++;
            $display("FAIL post_reset got=%0d/%b exp=%0d/00001", fd, {fm, p}, L); end
    endtask

    task automatic test_back_to_back();
        int d1 = -1, d2 = -1, nd = 0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int e = 1; e <= 2 * L + 6; e++) begin
            @(posedge clk); #1;
            if (e == L + 2) start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                if (d1 < 0) d1 = e; else if (d2 < 0) d2 = e;
            end
        end
        checks++; if (d1 != L || d2 != 2 * L + 2) begin failures++;
            $display("FAIL b2b_edges got=%0d,%0d exp=%0d,%0d", d1, d2, L, 2 * L + 2); end
        checks++; if (nd != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", nd); end
    endtask

    task automatic test_ignore_vcc();
        int fd, nd; logic [3:0] fm; logic p;
        ign_vcc = 1'b1;
        pulse_start();
        wait_done(1, -1, fd, nd, fm, p);
        ign_vcc = 1'b0;
        checks++; if (fd != L) begin failures++; $display("FAIL novcc_edge got=%0d exp=%0d", fd, L); end
`ifdef QUAD_AND_BIST_PWR_OFF_CHECK_EN
        checks++; if ({fm, p} !== 5'b1111_0) begin failures++;
            $display("FAIL novcc_result got=%b exp=11110", {fm, p}); end
`else
        checks++; if ({fm, p} !== 5'b0000_1) begin failures++;
            $display("FAIL novcc_result got=%b exp=00001", {fm, p}); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuck0_gate2();
        test_stuck1_gate0();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_ignore_vcc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
